// File: rtl/pe_dot_accum_if.sv
// Beat-in / result-out bundle for pe_dot_accum. The driver uses the master modport and the
// engine uses the slave modport.
interface pe_dot_accum_if #(
  parameter int unsigned NUM_FEATURES  = 2,
  parameter int unsigned NUM_FILTERS   = 2,
  parameter int unsigned DOT_SIZE      = 8,
  parameter int unsigned FEATURE_WIDTH = 8,
  parameter int unsigned FILTER_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH     = 32
) ();
  logic                                            i_valid;
  logic                                            i_first;
  logic                                            i_last;
  logic [NUM_FEATURES*DOT_SIZE*FEATURE_WIDTH-1:0]  i_feature;
  logic [NUM_FILTERS*DOT_SIZE*FILTER_WIDTH-1:0]    i_filter;
  logic                                            o_valid;
  logic [NUM_FEATURES*NUM_FILTERS*ACC_WIDTH-1:0]   o_result;
  logic [NUM_FEATURES*NUM_FILTERS-1:0]             o_sat;
  logic                                            o_busy;
  logic                                            o_err;

  modport master (
    output i_valid, i_first, i_last, i_feature, i_filter,
    input  o_valid, o_result, o_sat, o_busy, o_err
  );

  modport slave (
    input  i_valid, i_first, i_last, i_feature, i_filter,
    output o_valid, o_result, o_sat, o_busy, o_err
  );
endinterface

// File: rtl/pe_dot_accum.sv
// PE dot-product engine: NUM_FEATURES x NUM_FILTERS signed dot products per beat, pipelined,
// then accumulated with saturation over an i_first..i_last group.
module pe_dot_accum #(
  parameter int unsigned NUM_FEATURES  = 2,
  parameter int unsigned NUM_FILTERS   = 2,
  parameter int unsigned DOT_SIZE      = 8,
  parameter int unsigned FEATURE_WIDTH = 8,
  parameter int unsigned FILTER_WIDTH  = 8,
  parameter int unsigned MULT_LATENCY  = 1,
  parameter int unsigned TREE_LATENCY  = 2,
  parameter int unsigned ACC_WIDTH     = 32
) (
  input logic           clock,
  input logic           resetn,
  pe_dot_accum_if.slave bus
);
  localparam int unsigned ProdWidth = FEATURE_WIDTH + FILTER_WIDTH;
  localparam int unsigned DotWidth  = ProdWidth + $clog2(DOT_SIZE);
  localparam int unsigned Lanes     = NUM_FEATURES * NUM_FILTERS;
  localparam int unsigned CtrlDepth = MULT_LATENCY + TREE_LATENCY;
  // One spare bit over the wider of acc/dot so the sum itself can never wrap before clamping.
  localparam int unsigned SumWidth  = ((ACC_WIDTH > DotWidth) ? ACC_WIDTH : DotWidth) + 1;
  localparam logic signed [SumWidth-1:0] SumMax = SumWidth'({1'b0, {(ACC_WIDTH-1){1'b1}}});
  localparam logic signed [SumWidth-1:0] SumMin = ~SumMax;

  typedef enum logic {StIdle, StOpen} state_e;

  state_e                          r_state, w_state_d;
  logic signed [ProdWidth-1:0]     w_prod [Lanes][DOT_SIZE];
  logic signed [ProdWidth-1:0]     r_prod [MULT_LATENCY][Lanes][DOT_SIZE];
  logic signed [DotWidth-1:0]      w_tree [Lanes];
  logic signed [DotWidth-1:0]      r_dot  [TREE_LATENCY][Lanes];
  logic signed [SumWidth-1:0]      w_sum  [Lanes];
  logic [CtrlDepth-1:0]            r_vld, r_first, r_last;
  logic                            w_dv, w_first, w_last, w_start, w_err;
  logic [Lanes-1:0][ACC_WIDTH-1:0] r_acc, w_acc_d, r_result;
  logic [Lanes-1:0]                r_sat, w_sat_d, r_osat;
  logic                            r_ovalid;

  always_comb begin
    for (int unsigned f = 0; f < NUM_FEATURES; f++) begin
      for (int unsigned n = 0; n < NUM_FILTERS; n++) begin
        for (int unsigned k = 0; k < DOT_SIZE; k++) begin
          w_prod[f*NUM_FILTERS+n][k] =
            ProdWidth'($signed(bus.i_feature[(f*DOT_SIZE+k)*FEATURE_WIDTH +: FEATURE_WIDTH])) *
            ProdWidth'($signed(bus.i_filter[(n*DOT_SIZE+k)*FILTER_WIDTH +: FILTER_WIDTH]));
        end
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < Lanes; l++) begin
      w_tree[l] = '0;
      for (int unsigned k = 0; k < DOT_SIZE; k++) begin
        w_tree[l] = w_tree[l] + DotWidth'(r_prod[MULT_LATENCY-1][l][k]);
      end
    end
  end

  // Datapath registers carry no reset; only the control bits alongside them do.
  always_ff @(posedge clock) begin
    r_prod[0] <= w_prod;
    for (int unsigned s = 1; s < MULT_LATENCY; s++) r_prod[s] <= r_prod[s-1];
    r_dot[0] <= w_tree;
    for (int unsigned s = 1; s < TREE_LATENCY; s++) r_dot[s] <= r_dot[s-1];
  end

  assign w_dv    = r_vld[CtrlDepth-1];
  assign w_first = r_first[CtrlDepth-1];
  assign w_last  = r_last[CtrlDepth-1];

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    w_err     = 1'b0;
    if (w_dv) begin
      unique case (r_state)
        StIdle: begin
          w_start = 1'b1;
          w_err   = !w_first;
        end
        StOpen: begin
          w_start = w_first;
          w_err   = w_first;
        end
        default: ;
      endcase
      w_state_d = w_last ? StIdle : StOpen;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < Lanes; l++) begin
      w_sum[l] = SumWidth'(r_dot[TREE_LATENCY-1][l]);
      if (!w_start) w_sum[l] = w_sum[l] + SumWidth'($signed(r_acc[l]));
      w_sat_d[l] = w_start ? 1'b0 : r_sat[l];
      if (w_sum[l] > SumMax) begin
        w_acc_d[l] = SumMax[ACC_WIDTH-1:0];
        w_sat_d[l] = 1'b1;
      end else if (w_sum[l] < SumMin) begin
        w_acc_d[l] = SumMin[ACC_WIDTH-1:0];
        w_sat_d[l] = 1'b1;
      end else begin
        w_acc_d[l] = w_sum[l][ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_vld    <= '0;
      r_first  <= '0;
      r_last   <= '0;
      r_acc    <= '0;
      r_sat    <= '0;
      r_result <= '0;
      r_osat   <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_vld    <= {r_vld[CtrlDepth-2:0], bus.i_valid};
      r_first  <= {r_first[CtrlDepth-2:0], bus.i_valid & bus.i_first};
      r_last   <= {r_last[CtrlDepth-2:0], bus.i_valid & bus.i_last};
      r_state  <= w_state_d;
      r_ovalid <= w_dv & w_last;
      if (w_dv) begin
        r_acc <= w_acc_d;
        r_sat <= w_sat_d;
      end
      if (w_dv && w_last) begin
        r_result <= w_acc_d;
        r_osat   <= w_sat_d;
      end
    end
  end

  assign bus.o_valid  = r_ovalid;
  assign bus.o_result = r_result;
  assign bus.o_sat    = r_osat;
  assign bus.o_busy   = (w_state_d == StOpen);
  assign bus.o_err    = w_err;
endmodule

// File: tb/tb_pe_dot_accum.sv
// Directed bench for pe_dot_accum: a 32-bit-accumulator instance and a 16-bit one share the
// same stimulus so saturation and exact extreme sums can be checked side by side.
module tb_pe_dot_accum;
  localparam int unsigned NF = 2, NN = 2, K = 8, FW = 8, WW = 8, AW = 32, AWB = 16;
  localparam int unsigned LANES = NF * NN;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic              t_valid, t_first, t_last;
  logic [NF*K*FW-1:0] t_feat;
  logic [NN*K*WW-1:0] t_filt;

  pe_dot_accum_if #(.NUM_FEATURES(NF), .NUM_FILTERS(NN), .DOT_SIZE(K), .FEATURE_WIDTH(FW),
                    .FILTER_WIDTH(WW), .ACC_WIDTH(AW)) if_a ();
  pe_dot_accum_if #(.NUM_FEATURES(NF), .NUM_FILTERS(NN), .DOT_SIZE(K), .FEATURE_WIDTH(FW),
                    .FILTER_WIDTH(WW), .ACC_WIDTH(AWB)) if_b ();

  assign if_a.i_valid = t_valid;  assign if_b.i_valid = t_valid;
  assign if_a.i_first = t_first;  assign if_b.i_first = t_first;
  assign if_a.i_last = t_last;    assign if_b.i_last = t_last;
  assign if_a.i_feature = t_feat; assign if_b.i_feature = t_feat;
  assign if_a.i_filter = t_filt;  assign if_b.i_filter = t_filt;

  pe_dot_accum #(.NUM_FEATURES(NF), .NUM_FILTERS(NN), .DOT_SIZE(K), .FEATURE_WIDTH(FW),
                 .FILTER_WIDTH(WW), .MULT_LATENCY(1), .TREE_LATENCY(2), .ACC_WIDTH(AW))
    dut_a (.clock(clock), .resetn(resetn), .bus(if_a));
  pe_dot_accum #(.NUM_FEATURES(NF), .NUM_FILTERS(NN), .DOT_SIZE(K), .FEATURE_WIDTH(FW),
                 .FILTER_WIDTH(WW), .MULT_LATENCY(1), .TREE_LATENCY(2), .ACC_WIDTH(AWB))
    dut_b (.clock(clock), .resetn(resetn), .bus(if_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int va_cnt, vb_cnt, err_cnt, err_cyc, busy_cnt, busy_cyc;
  int va_cyc [8];
  logic [LANES*AW-1:0]  va_res [8];
  logic [LANES-1:0]     va_sat;
  logic [LANES*AWB-1:0] vb_res;
  logic [LANES-1:0]     vb_sat;

  task automatic clr();
    va_cnt = 0; vb_cnt = 0; err_cnt = 0; err_cyc = -1; busy_cnt = 0; busy_cyc = -1;
  endtask

  // Advance one clock and record output events, sampling 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (if_a.o_valid === 1'b1) begin
      if (va_cnt < 8) begin
        va_res[va_cnt] = if_a.o_result;
        va_cyc[va_cnt] = cyc;
      end
      va_sat = if_a.o_sat;
      va_cnt++;
    end
    if (if_b.o_valid === 1'b1) begin
      vb_res = if_b.o_result;
      vb_sat = if_b.o_sat;
      vb_cnt++;
    end
    if (if_a.o_err === 1'b1) begin
      if (err_cnt == 0) err_cyc = cyc;
      err_cnt++;
    end
    if (if_a.o_busy === 1'b1) begin
      if (busy_cnt == 0) busy_cyc = cyc;
      busy_cnt++;
    end
  endtask

  task automatic idle(input int n);
    t_valid = 1'b0; t_first = 1'b0; t_last = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input logic f, input logic l, input logic [NF*K*FW-1:0] fe,
                      input logic [NN*K*WW-1:0] fi);
    t_valid = 1'b1; t_first = f; t_last = l; t_feat = fe; t_filt = fi;
    tick();
    t_valid = 1'b0; t_first = 1'b0; t_last = 1'b0;
  endtask

  function automatic logic [NF*K*FW-1:0] feat_all(input logic [7:0] v);
    logic [NF*K*FW-1:0] r;
    for (int i = 0; i < int'(NF*K); i++) r[i*FW +: FW] = v;
    return r;
  endfunction

  function automatic logic [NN*K*WW-1:0] filt_all(input logic [7:0] v);
    logic [NN*K*WW-1:0] r;
    for (int i = 0; i < int'(NN*K); i++) r[i*WW +: WW] = v;
    return r;
  endfunction

  // Element 0 of every vector carries v, the rest are zero: paired with filt_e0(1) the dot is v.
  function automatic logic [NF*K*FW-1:0] feat_e0(input logic [7:0] v);
    logic [NF*K*FW-1:0] r;
    r = '0;
    for (int f = 0; f < int'(NF); f++) r[f*K*FW +: FW] = v;
    return r;
  endfunction

  function automatic logic [NN*K*WW-1:0] filt_e0(input logic [7:0] v);
    logic [NN*K*WW-1:0] r;
    r = '0;
    for (int n = 0; n < int'(NN); n++) r[n*K*WW +: WW] = v;
    return r;
  endfunction

  task automatic test_reset();
    t_valid = 1'b0; t_first = 1'b0; t_last = 1'b0; t_feat = '0; t_filt = '0;
    resetn = 1'b0;
    clr();
    tick(); tick();
    checks++;
    if (if_a.o_valid !== 1'b0 || if_a.o_busy !== 1'b0 || if_a.o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: valid/busy/err=%b%b%b required 000",
               if_a.o_valid, if_a.o_busy, if_a.o_err);
    end
    checks++;
    if (if_a.o_result !== '0 || if_a.o_sat !== '0) begin
      errors++;
      $display("FAIL reset_data_a: result=%h sat=%b required 0", if_a.o_result, if_a.o_sat);
    end
    checks++;
    if (if_b.o_valid !== 1'b0 || if_b.o_result !== '0 || if_b.o_sat !== '0) begin
      errors++;
      $display("FAIL reset_b: valid=%b result=%h sat=%b required 0",
               if_b.o_valid, if_b.o_result, if_b.o_sat);
    end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_beat();
    int t0;
    clr();
    t0 = cyc;
    beat(1'b1, 1'b1, feat_all(8'h01), filt_all(8'h02));
    idle(6);
    checks++;
    if (va_cnt !== 1 || va_cyc[0] !== t0 + 4) begin
      errors++;
      $display("FAIL single_latency: count=%0d cycle=%0d required 1 at %0d",
               va_cnt, va_cyc[0], t0 + 4);
    end
    for (int l = 0; l < int'(LANES); l++) begin
      checks++;
      if ($signed(va_res[0][l*AW +: AW]) !== 32'sd16) begin
        errors++;
        $display("FAIL single_lane%0d: got %0d required 16", l, $signed(va_res[0][l*AW +: AW]));
      end
    end
  endtask

  task automatic test_lanes();
    logic [NF*K*FW-1:0] fe;
    logic [NN*K*WW-1:0] fi;
    int exp_l [LANES] = '{36, 5, -36, -5};
    for (int k = 0; k < int'(K); k++) begin
      fe[k*FW +: FW]       = 8'(k + 1);
      fe[(K+k)*FW +: FW]   = 8'(-(k + 1));
      fi[k*WW +: WW]       = 8'h01;
      fi[(K+k)*WW +: WW]   = (k == 0) ? 8'h05 : 8'h00;
    end
    clr();
    beat(1'b1, 1'b1, fe, fi);
    idle(6);
    for (int l = 0; l < int'(LANES); l++) begin
      checks++;
      if (va_cnt !== 1 || $signed(va_res[0][l*AW +: AW]) !== exp_l[l]) begin
        errors++;
        $display("FAIL lanes_lane%0d: got %0d (count %0d) required %0d",
                 l, $signed(va_res[0][l*AW +: AW]), va_cnt, exp_l[l]);
      end
    end
  endtask

  task automatic test_gaps();
    int t0;
    clr();
    t0 = cyc;
    beat(1'b1, 1'b0, feat_e0(8'h05), filt_e0(8'h01));
    idle(1);
    beat(1'b0, 1'b0, feat_e0(8'hF9), filt_e0(8'h01));
    idle(1);
    beat(1'b0, 1'b1, feat_e0(8'h64), filt_e0(8'h01));
    idle(6);
    checks++;
    if (va_cnt !== 1 || va_cyc[0] !== t0 + 8) begin
      errors++;
      $display("FAIL gaps_valid: count=%0d cycle=%0d required 1 at %0d",
               va_cnt, va_cyc[0], t0 + 8);
    end
    for (int l = 0; l < int'(LANES); l++) begin
      checks++;
      if ($signed(va_res[0][l*AW +: AW]) !== 32'sd98) begin
        errors++;
        $display("FAIL gaps_lane%0d: got %0d required 98", l, $signed(va_res[0][l*AW +: AW]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clr();
    t0 = cyc;
    beat(1'b1, 1'b0, feat_e0(8'h01), filt_e0(8'h01));
    beat(1'b0, 1'b0, feat_e0(8'h02), filt_e0(8'h01));
    beat(1'b0, 1'b1, feat_e0(8'h03), filt_e0(8'h01));
    beat(1'b1, 1'b1, feat_e0(8'hFC), filt_e0(8'h01));
    idle(6);
    checks++;
    if (busy_cnt !== 2 || busy_cyc !== t0 + 3) begin
      errors++;
      $display("FAIL b2b_busy: %0d cycles from %0d required 2 from %0d",
               busy_cnt, busy_cyc, t0 + 3);
    end
    checks++;
    if (va_cnt !== 2 || va_cyc[0] !== t0 + 6 || va_cyc[1] !== t0 + 7) begin
      errors++;
      $display("FAIL b2b_valid: count=%0d at %0d,%0d required 2 at %0d,%0d",
               va_cnt, va_cyc[0], va_cyc[1], t0 + 6, t0 + 7);
    end
    checks++;
    if ($signed(va_res[0][0 +: AW]) !== 32'sd6 || $signed(va_res[1][AW +: AW]) !== -32'sd4) begin
      errors++;
      $display("FAIL b2b_result: got %0d,%0d required 6,-4",
               $signed(va_res[0][0 +: AW]), $signed(va_res[1][AW +: AW]));
    end
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL b2b_err: %0d pulses required 0", err_cnt);
    end
  endtask

  task automatic test_saturation();
    clr();
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9, feat_all(8'h7F), filt_all(8'h7F));
    idle(6);
    checks++;
    if (vb_cnt !== 1 || $signed(vb_res[AWB +: AWB]) !== 16'sd32767 || vb_sat !== 4'hF) begin
      errors++;
      $display("FAIL sat_b: count=%0d result=%0d sat=%b required 1 32767 1111",
               vb_cnt, $signed(vb_res[AWB +: AWB]), vb_sat);
    end
    checks++;
    if ($signed(va_res[0][3*AW +: AW]) !== 32'sd1290320 || va_sat !== 4'h0) begin
      errors++;
      $display("FAIL sat_a_exact: result=%0d sat=%b required 1290320 0000",
               $signed(va_res[0][3*AW +: AW]), va_sat);
    end
    clr();
    beat(1'b1, 1'b1, feat_all(8'h01), filt_all(8'h02));
    idle(6);
    checks++;
    if (vb_cnt !== 1 || $signed(vb_res[0 +: AWB]) !== 16'sd16 || vb_sat !== 4'h0) begin
      errors++;
      $display("FAIL sat_clear_b: count=%0d result=%0d sat=%b required 1 16 0000",
               vb_cnt, $signed(vb_res[0 +: AWB]), vb_sat);
    end
  endtask

  task automatic test_framing();
    int t0;
    clr();
    t0 = cyc;
    beat(1'b0, 1'b0, feat_e0(8'h05), filt_e0(8'h01));
    beat(1'b1, 1'b0, feat_e0(8'h07), filt_e0(8'h01));
    beat(1'b0, 1'b1, feat_e0(8'h0B), filt_e0(8'h01));
    idle(6);
    checks++;
    if (err_cnt !== 2 || err_cyc !== t0 + 3) begin
      errors++;
      $display("FAIL framing_err: %0d pulses first at %0d required 2 first at %0d",
               err_cnt, err_cyc, t0 + 3);
    end
    checks++;
    if (va_cnt !== 1 || $signed(va_res[0][2*AW +: AW]) !== 32'sd18) begin
      errors++;
      $display("FAIL framing_result: count=%0d result=%0d required 1 18",
               va_cnt, $signed(va_res[0][2*AW +: AW]));
    end
  endtask

  task automatic test_extremes();
    clr();
    beat(1'b1, 1'b1, feat_all(8'h80), filt_all(8'h80));
    beat(1'b1, 1'b1, feat_all(8'h80), filt_all(8'h7F));
    idle(6);
    checks++;
    if (va_cnt !== 2 || $signed(va_res[0][1*AW +: AW]) !== 32'sd131072 || va_sat !== 4'h0) begin
      errors++;
      $display("FAIL ext_pos: count=%0d result=%0d required 2 131072",
               va_cnt, $signed(va_res[0][1*AW +: AW]));
    end
    checks++;
    if ($signed(va_res[1][2*AW +: AW]) !== -32'sd130048) begin
      errors++;
      $display("FAIL ext_neg: got %0d required -130048", $signed(va_res[1][2*AW +: AW]));
    end
    checks++;
    if (vb_cnt !== 2 || $signed(vb_res[0 +: AWB]) !== -16'sd32768 || vb_sat !== 4'hF) begin
      errors++;
      $display("FAIL ext_b_clamp: count=%0d result=%0d sat=%b required 2 -32768 1111",
               vb_cnt, $signed(vb_res[0 +: AWB]), vb_sat);
    end
  endtask

  task automatic test_reset_mid_group();
    clr();
    beat(1'b1, 1'b0, feat_e0(8'h05), filt_e0(8'h01));
    for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, feat_e0(8'h05), filt_e0(8'h01));
    checks++;
    if (if_a.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: got %b required 1", if_a.o_busy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (if_a.o_result !== '0 || if_a.o_sat !== '0 || if_a.o_busy !== 1'b0 ||
        if_a.o_valid !== 1'b0 || if_a.o_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: result=%h sat=%b busy=%b valid=%b err=%b required 0",
               if_a.o_result, if_a.o_sat, if_a.o_busy, if_a.o_valid, if_a.o_err);
    end
    tick();
    resetn = 1'b1;
    idle(8);
    checks++;
    if (va_cnt !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_stale: valid count=%0d err count=%0d required 0 0", va_cnt, err_cnt);
    end
    beat(1'b1, 1'b1, feat_all(8'h01), filt_all(8'h02));
    idle(6);
    checks++;
    if (va_cnt !== 1 || $signed(va_res[0][3*AW +: AW]) !== 32'sd16) begin
      errors++;
      $display("FAIL midrst_new: count=%0d result=%0d required 1 16",
               va_cnt, $signed(va_res[0][3*AW +: AW]));
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_lanes();
    test_gaps();
    test_back_to_back();
    test_saturation();
    test_framing();
    test_extremes();
    test_reset_mid_group();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
